i2c_write_master: RTL and testbench



---
 rtl/i2c_write_master.sv | 129 ++++++++++++
 tb/tb_i2c_write_master.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/i2c_write_master.sv
// i2c_write_master: bit-level I2C write engine sending START, 3 bytes with ack slots, then STOP.
// Ports:
//   iCLK      system clock
//   iRST_N    asynchronous active-low reset
//   iDATA     24-bit transfer word, [23:16] sent first, latched on accept
//   iGO       level request, held until oEND then dropped
//   oEND      transfer complete, held until iGO goes low
//   oACK      1 when any acknowledge slot of the last transfer read high
//   oBUSY     transfer in progress
//   I2C_SCLK  SCL, push-pull
//   I2C_SDAT  SDA, open-drain (drives 0 or released)
module i2c_write_master #(
   parameter int CLK_FREQ = 50000000,
   parameter int I2C_FREQ = 20000
) (
   input  logic        iCLK,
   input  logic        iRST_N,
   input  logic [23:0] iDATA,
   input  logic        iGO,
   output logic        oEND,
   output logic        oACK,
   output logic        oBUSY,
   output logic        I2C_SCLK,
   inout  wire         I2C_SDAT
);
   localparam int Q  = CLK_FREQ / (4 * I2C_FREQ);
   localparam int DW = $clog2(Q);

   typedef enum logic [2:0] {IDLE, START, SHIFT, STOP, DONE} state_t;

   state_t        state, state_n;
   logic [DW-1:0] div, div_n;
   logic [1:0]    qtr, qtr_n;
   logic [4:0]    slot, slot_n;
   logic [23:0]   sh, sh_n;
   logic          ack_n, busy_n, end_n;
   logic          sda_s1, sda_s2;
   logic          tick, ack_slot, sda_low;

   assign I2C_SDAT = sda_low ? 1'b0 : 1'bz;

   always_ff @(posedge iCLK or negedge iRST_N)
      if (!iRST_N) begin
         state  <= IDLE;
         div    <= '0;
         qtr    <= '0;
         slot   <= '0;
         sh     <= '0;
         oACK   <= 1'b0;
         oBUSY  <= 1'b0;
         oEND   <= 1'b0;
         sda_s1 <= 1'b1;
         sda_s2 <= 1'b1;
      end else begin
         state  <= state_n;
         div    <= div_n;
         qtr    <= qtr_n;
         slot   <= slot_n;
         sh     <= sh_n;
         oACK   <= ack_n;
         oBUSY  <= busy_n;
         oEND   <= end_n;
         sda_s1 <= I2C_SDAT;
         sda_s2 <= sda_s1;
      end

   always_comb begin
      state_n  = state;
      div_n    = div;
      qtr_n    = qtr;
      slot_n   = slot;
      sh_n     = sh;
      ack_n    = oACK;
      busy_n   = oBUSY;
      end_n    = oEND;
      I2C_SCLK = 1'b1;
      sda_low  = 1'b0;
      tick     = oBUSY && (div == DW'(Q - 1));
      ack_slot = (slot == 5'd8) || (slot == 5'd17) || (slot == 5'd26);
      if (oBUSY) begin
         div_n = tick ? '0 : div + 1'b1;
         qtr_n = tick ? qtr + 1'b1 : qtr;
      end
      case (state)
         IDLE:
            if (iGO && !oEND) begin
               state_n = START;
               sh_n    = iDATA;
               ack_n   = 1'b0;
               busy_n  = 1'b1;
               div_n   = '0;
               qtr_n   = '0;
               slot_n  = '0;
            end
         START: begin
            I2C_SCLK = qtr != 2'd3;
            sda_low  = qtr != 2'd0;
            if (tick && qtr == 2'd3) state_n = SHIFT;
         end
         SHIFT: begin
            // SDA is set only in q0 while SCL is low; ack slots release the line
            I2C_SCLK = (qtr == 2'd1) || (qtr == 2'd2);
            sda_low  = !ack_slot && !sh[23];
            if (tick && qtr == 2'd2 && ack_slot) ack_n = oACK | sda_s2;
            if (tick && qtr == 2'd3) begin
               slot_n = slot + 1'b1;
               if (!ack_slot) sh_n = {sh[22:0], 1'b0};
               if (slot == 5'd26) state_n = STOP;
            end
         end
         STOP: begin
            I2C_SCLK = qtr != 2'd0;
            sda_low  = qtr < 2'd2;
            if (tick && qtr == 2'd3) begin
               state_n = DONE;
               busy_n  = 1'b0;
            end
         end
         DONE:
            // first cycle raises oEND so it is visible at least once even if iGO is already low
            if (!oEND) end_n = 1'b1;
            else if (!iGO) begin
               end_n   = 1'b0;
               state_n = IDLE;
            end
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_i2c_write_master.sv
// tb_i2c_write_master: table-driven bench for i2c_write_master with a bus monitor and ACKing slave model.
module tb_i2c_write_master;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        go = 1'b0;
   logic [23:0] data = '0;
   logic        end_o, ack_o, busy_o, scl;
   logic        end2, ack2, busy2, scl2;
   wire         sda, sda2;
   logic        slv = 1'b0;
   logic [2:0]  mask = 3'b111;

   pullup   pu (sda);
   pulldown pd (sda2);
   assign sda = slv ? 1'b0 : 1'bz;

   always #5 clk = ~clk;

   i2c_write_master #(.CLK_FREQ(400), .I2C_FREQ(25)) dut (
      .iCLK(clk), .iRST_N(rst_n), .iDATA(data), .iGO(go),
      .oEND(end_o), .oACK(ack_o), .oBUSY(busy_o), .I2C_SCLK(scl), .I2C_SDAT(sda)
   );

   // second copy on a pulled-down line: any 1 seen there was driven by the master
   i2c_write_master #(.CLK_FREQ(400), .I2C_FREQ(25)) dut2 (
      .iCLK(clk), .iRST_N(rst_n), .iDATA(data), .iGO(go),
      .oEND(end2), .oACK(ack2), .oBUSY(busy2), .I2C_SCLK(scl2), .I2C_SDAT(sda2)
   );

   logic        p_scl = 1'b1, p_sda = 1'b1;
   int          nbits = 0, starts = 0, stops = 0, bad2 = 0;
   logic [26:0] bits = '0;

   always @(negedge clk) begin
      if (p_scl && scl && p_sda && !sda) begin
         starts <= starts + 1;
         nbits  <= 0;
      end
      if (p_scl && scl && !p_sda && sda) stops <= stops + 1;
      if (!p_scl && scl && nbits < 27) begin
         bits[26-nbits] <= sda;
         nbits          <= nbits + 1;
      end
      if (p_scl && !scl) slv <= (nbits % 9 == 8) && mask[nbits/9];
      if (sda2 !== 1'b0) bad2 <= bad2 + 1;
      p_scl <= scl;
      p_sda <= sda;
   end

   typedef struct {
      logic [23:0] data;
      logic [2:0]  mask;
      logic        exp_ack;
      logic        hold;
      logic        disturb;
      logic        rst;
   } vec_t;

   vec_t vecs[6];
   int   checks = 0, fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic xfer(input vec_t v);
      int          s0, p0, n, bad;
      logic [26:0] eb;
      data = v.data;
      mask = v.mask;
      go   = 1'b1;
      s0   = starts;
      p0   = stops;
      @(posedge clk);
      @(negedge clk);
      chk("accept_busy_ack", {30'd0, busy_o, ack_o}, 32'd2);
      n = 0;
      while (!end_o && n < 600) begin
         if (v.disturb && n == 50) begin
            data = 24'hFFFFFF;
            go   = 1'b0;
         end
         if (v.disturb && n == 51) go = 1'b1;
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      chk("end_latency", n, 465);
      eb = {v.data[23:16], ~v.mask[0], v.data[15:8], ~v.mask[1], v.data[7:0], ~v.mask[2]};
      chk("bits", {5'd0, bits}, {5'd0, eb});
      chk("ack", {31'd0, ack_o}, {31'd0, v.exp_ack});
      chk("start_count", starts - s0, 1);
      chk("stop_count", stops - p0, 1);
      if (v.hold) begin
         bad = 0;
         repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            if (!end_o || busy_o || starts != s0 + 1) bad++;
         end
         chk("hold_no_restart", bad, 0);
      end
      go = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("end_drop", {31'd0, end_o}, 32'd0);
   endtask

   initial begin
      vecs[0] = '{24'hBA2000, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{24'hBAF101, 3'b110, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{24'hBA0907, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{24'hBA2B00, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[4] = '{24'hBA2B00, 3'b111, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[5] = '{24'h123456, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0};
      #12;
      chk("reset_state", {27'd0, scl, sda, busy_o, end_o, ack_o}, 32'b11000);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      foreach (vecs[i]) begin
         if (vecs[i].rst) begin
            int s0, n;
            s0   = starts;
            data = vecs[i].data;
            mask = vecs[i].mask;
            go   = 1'b1;
            n    = 0;
            while (!(starts > s0 && nbits == 14) && n < 1000) begin
               @(posedge clk);
               n++;
            end
            chk("reset_reached", {31'd0, n < 1000}, 32'd1);
            #2 rst_n = 1'b0;
            #1 chk("reset_mid", {28'd0, scl, sda, busy_o, end_o}, 32'b1100);
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
         end
         xfer(vecs[i]);
      end
      chk("sda_never_high", bad2, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
